// File: rtl/npc_lsu_pkg.sv
// Shared types for the NPC load/store unit: access sizes and FSM states.
package npc_lsu_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_RESP} lsu_state_e;

    // Byte-enable pattern for an access of the given size at offset 0.
    function automatic logic [7:0] size_mask(lsu_size_e s);
        case (s)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering for the LSU: 128-bit write shift and mask, read merge/shift/extend.
module lsu_align
    import npc_lsu_pkg::*;
(
    input  lsu_size_e     size,
    input  logic          zext,
    input  logic [2:0]    off,
    input  logic [63:0]   wdata,
    input  logic [63:0]   lo,
    input  logic [63:0]   hi,
    output logic [15:0]   bmask,
    output logic [127:0]  wshift,
    output logic [63:0]   rdata
);

    logic [5:0]   sh;
    logic [127:0] rshift;

    assign sh     = {off, 3'b000};
    assign bmask  = {8'h00, size_mask(size)} << off;
    assign wshift = {64'h0, wdata} << sh;
    assign rshift = {hi, lo} >> sh;

    always_comb begin
        rdata = rshift[63:0];
        case (size)
            SZ_B:    rdata = zext ? {56'h0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
            SZ_H:    rdata = zext ? {48'h0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
            SZ_W:    rdata = zext ? {32'h0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
            default: rdata = rshift[63:0];
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// NPC load/store unit driving the 8-byte-aligned simulation memory port.
// LSU_MISALIGN_EN: split line-crossing accesses into two beats instead of faulting.
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state;
    logic              wr_q;
    lsu_size_e         size_q;
    logic              zext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] lo_q;
    logic              cross_q;

    lsu_size_e         al_size;
    logic [2:0]        al_off;
    logic [DATA_W-1:0] al_lo;
    logic [15:0]       bmask;
    logic [127:0]      wshift;
    logic [DATA_W-1:0] ld_data;
    logic              cross_now;
    logic [ADDR_W-1:0] base;

    // While idle the aligner looks at the incoming request so the crossing
    // decision is available on the accept edge.
    assign al_size   = (state == ST_IDLE) ? lsu_size_e'(req_size) : size_q;
    assign al_off    = (state == ST_IDLE) ? req_addr[2:0] : addr_q[2:0];
    assign al_lo     = (state == ST_BEAT0) ? mem_rdata : lo_q;
    assign cross_now = |bmask[15:8];
    assign base      = {addr_q[ADDR_W-1:3], 3'b000};

    lsu_align u_align (
        .size   (al_size),
        .zext   (zext_q),
        .off    (al_off),
        .wdata  (wdata_q),
        .lo     (al_lo),
        .hi     (mem_rdata),
        .bmask  (bmask),
        .wshift (wshift),
        .rdata  (ld_data)
    );

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= SZ_B;
            zext_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            cross_q    <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        size_q  <= lsu_size_e'(req_size);
                        zext_q  <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cross_q <= cross_now;
`ifdef LSU_MISALIGN_EN
                        state   <= ST_BEAT0;
`else
                        if (cross_now) begin
                            state      <= ST_RESP;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= ST_BEAT0;
                        end
`endif
                    end
                end
                ST_BEAT0: begin
                    lo_q <= mem_rdata;
                    if (cross_q) begin
                        state <= ST_BEAT1;
                    end else begin
                        state      <= ST_RESP;
                        resp_rdata <= wr_q ? '0 : ld_data;
                        resp_err   <= 1'b0;
                    end
                end
                ST_BEAT1: begin
                    state      <= ST_RESP;
                    resp_rdata <= wr_q ? '0 : ld_data;
                    resp_err   <= 1'b0;
                end
                default: begin
                    if (resp_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_raddr = '0;
        mem_write = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wmask = 8'h00;
        if (state == ST_BEAT0 || state == ST_BEAT1) begin
            if (wr_q) begin
                mem_write = 1'b1;
                if (state == ST_BEAT0) begin
                    mem_waddr = base;
                    mem_wmask = bmask[7:0];
                    mem_wdata = wshift[63:0];
                end else begin
                    mem_waddr = base + ADDR_W'(8);
                    mem_wmask = bmask[15:8];
                    mem_wdata = wshift[127:64];
                end
            end else begin
                mem_read  = 1'b1;
                mem_raddr = (state == ST_BEAT0) ? base : base + ADDR_W'(8);
            end
        end
    end

endmodule

// File: tb/tb_npc_lsu.sv
// Self-checking bench for npc_lsu: vector table, byte-level reference memory, response scoreboard.
module tb_npc_lsu;

`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_wmask;

    always #5 clk = ~clk;

    npc_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_read(mem_read), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    // Word memory seen by the DUT; the few regions used are folded into 32 words.
    logic [63:0] dmem [32];
    function automatic int widx(input logic [63:0] a);
        return int'({a[31], a[6:3]});
    endfunction
    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] r;
        r = o;
        for (int j = 0; j < 8; j++) if (m[j]) r[8*j +: 8] = d[8*j +: 8];
        return r;
    endfunction

    always_comb mem_rdata = mem_read ? dmem[widx(mem_raddr)] : 64'h0;
    always @(posedge clk) if (mem_write) dmem[widx(mem_waddr)] <= merge(dmem[widx(mem_waddr)], mem_wdata, mem_wmask);

    // Independent byte-addressed reference memory.
    logic [7:0] refm [logic [63:0]];
    function automatic logic [7:0] rb(input logic [63:0] a);
        return refm.exists(a) ? refm[a] : 8'h00;
    endfunction

    typedef struct { logic [63:0] rd; logic err; } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic w; logic [1:0] sz; logic u; logic [63:0] addr; logic [63:0] wdata;
        int hold; logic has_c; logic [63:0] c;
    } vec_t;
    vec_t vt[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] w);
        dmem[widx(a)] = w;
        for (int i = 0; i < 8; i++) refm[a + 64'(i)] = w[8*i +: 8];
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold, output logic [63:0] got);
        int nb, off, nbeats, lat, beats, exp_lat;
        logic cr;
        exp_t e;
        logic [15:0] m16;
        logic [7:0] eb [16];
        logic [63:0] ra [2];
        logic [63:0] wd [2];
        logic [7:0] wm [2];
        logic [63:0] v, snap_rd, ew, mm;
        logic snap_err;
        got = '0;
        nb = 1 << sz; off = int'(addr[2:0]); cr = (off + nb) > 8;
        m16 = '0;
        for (int i = 0; i < 16; i++) eb[i] = 8'h00;
        for (int i = 0; i < nb; i++) begin m16[off+i] = 1'b1; eb[off+i] = wdata[8*i +: 8]; end
        // Reference behaviour.
        if (cr && !MIS) begin
            e.rd = '0; e.err = 1'b1; nbeats = 0;
        end else begin
            e.err = 1'b0; nbeats = cr ? 2 : 1; e.rd = '0;
            if (w) begin
                for (int i = 0; i < nb; i++) refm[addr + 64'(i)] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = rb(addr + 64'(i));
                if (!u && nb < 8 && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.rd = v;
            end
        end
        exp_lat = (nbeats == 0) ? 1 : nbeats + 1;

        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = addr; req_wdata = wdata; resp_ready = (hold == 0);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; beats = 0;
        while (!resp_valid && lat < 10) begin
            if ((mem_read || mem_write) && beats < 2) begin
                ra[beats] = w ? mem_waddr : mem_raddr;
                wd[beats] = mem_wdata; wm[beats] = mem_wmask;
                beats++;
            end
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 64'(resp_valid), 64'd1);
            void'(sbq.pop_front());
            return;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("beats", 64'(beats), 64'(nbeats));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        for (int b = 0; b < beats; b++) begin
            chk("beat_addr", ra[b], {addr[63:3], 3'b000} + 64'(8 * b));
            if (w) begin
                chk("beat_wmask", 64'(wm[b]), 64'(m16[8*b +: 8]));
                ew = '0; mm = '0;
                for (int j = 0; j < 8; j++) if (m16[8*b+j]) begin ew[8*j +: 8] = eb[8*b+j]; mm[8*j +: 8] = 8'hFF; end
                chk("beat_wdata", wd[b] & mm, ew);
            end
        end
        snap_rd = resp_rdata; snap_err = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, snap_rd);
            chk("hold_err", 64'(resp_err), 64'(snap_err));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", 64'(resp_err), 64'(e.err));
        got = resp_rdata;
        @(negedge clk);
        chk("released", {62'h0, resp_valid, req_ready}, 64'h1);
        chk("mem_idle", {54'h0, mem_wmask, mem_read, mem_write}, 64'h0);
    endtask

    initial begin
        logic [63:0] got;
        for (int i = 0; i < 32; i++) dmem[i] = 64'h0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp", {62'h0, resp_valid, resp_err}, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_mem", {54'h0, mem_wmask, mem_read, mem_write} | mem_raddr | mem_waddr | mem_wdata, 64'h0);
        rst = 1'b0;

        preload(64'h8000_0010, 64'h0000_0000_0000_80FF);

        vt.push_back('{1'b1, 2'd3, 1'b0, 64'h8000_0000, 64'h1122334455667788, 0, 1'b0, 64'h0});
        vt.push_back('{1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 0, 1'b1, 64'h1122334455667788});
        vt.push_back('{1'b0, 2'd0, 1'b0, 64'h8000_0011, 64'h0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80});
        vt.push_back('{1'b0, 2'd0, 1'b1, 64'h8000_0011, 64'h0, 0, 1'b1, 64'h80});
        vt.push_back('{1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hAABBCCDD, 0, 1'b0, 64'h0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'h0, 0, MIS, 64'hFFFF_FFFF_AABB_CCDD});
        vt.push_back('{1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 5, !MIS, 64'h1122334455667788});
        vt.push_back('{1'b1, 2'd1, 1'b0, 64'h8000_0023, 64'hBEEF, 0, 1'b0, 64'h0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 64'h8000_0023, 64'h0, 0, 1'b1, 64'hBEEF});
        vt.push_back('{1'b0, 2'd2, 1'b0, 64'h8000_0024, 64'h0, 0, 1'b0, 64'h0});
        vt.push_back('{1'b1, 2'd0, 1'b0, 64'h8000_0030, 64'hFF, 0, 1'b0, 64'h0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 64'h8000_0030, 64'h0, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vt.push_back('{1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0102030405060708, 0, 1'b0, 64'h0});
        vt.push_back('{1'b0, 2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 0, 1'b0, 64'h0});
        vt.push_back('{1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 0, 1'b0, 64'h0});
        for (int i = 0; i < 24; i++)
            vt.push_back('{1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           64'h8000_0040 + 64'($urandom_range(0, 31)), {$urandom, $urandom}, 0, 1'b0, 64'h0});

        foreach (vt[k]) begin
            do_req(vt[k].w, vt[k].sz, vt[k].u, vt[k].addr, vt[k].wdata, vt[k].hold, got);
            if (vt[k].has_c) chk("const_rdata", got, vt[k].c);
        end

        // Reset in the middle of a load: nothing must survive.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = MIS ? 64'h8000_0006 : 64'h8000_0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (MIS) begin
            @(negedge clk);
            chk("beat1_raddr", mem_raddr, 64'h8000_0008);
        end
        chk("mid_read", 64'(mem_read), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_read", 64'(mem_read), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_stays", {62'h0, resp_valid, req_ready}, 64'h1);

        // Memory still serves correctly after the aborted request.
        do_req(1'b0, 2'd3, 1'b1, 64'h8000_0010, 64'h0, 0, got);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/npc_lsu.md
# npc_lsu

Load/store unit for the NPC core: the initiator side of the simulation memory port. It takes one load or store request from the execute stage, drives the 8-byte-aligned `mem_*` read/write port of the DPI memory model, and merges and extends the returned bytes. It replies with a registered response. The memory port answers combinationally within the beat cycle; the LSU supplies all sequencing, byte-lane steering and response buffering.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width. Fixed at 64 for the memory port.
- `clk` in, 1: clock. All logic is on the rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: LSU can accept a request. High only in IDLE.
- `req_write` in, 1: 1 = store, 0 = load.
- `req_size` in, 2: access size. 0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned` in, 1: zero-extend the load result. Ignored for stores.
- `req_addr` in, 64: byte address.
- `req_wdata` in, 64: store data, right-aligned.
- `resp_valid` out, 1: response present.
- `resp_ready` in, 1: consumer takes the response.
- `resp_rdata` out, 64: extended load data. 0 for stores.
- `resp_err` out, 1: misaligned-crossing fault.
- `mem_raddr` out, 64: read address, always 8-byte aligned.
- `mem_read` out, 1: read strobe.
- `mem_waddr` out, 64: write address, always 8-byte aligned.
- `mem_wdata` out, 64: write data, lane-shifted.
- `mem_wmask` out, 8: write byte mask.
- `mem_write` out, 1: write strobe.
- `mem_rdata` in, 64: read data. Valid in the same cycle as `mem_read`.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- Accepting a request:
  - The request is accepted on the edge where `req_valid & req_ready`.
  - All request fields are latched. `off = addr[2:0]`. `bmask16 = ((1<<(1<<size))-1) << off`, 16 bits wide.
  - `cross = |bmask16[15:8]`.
- IDLE -> BEAT0 on accept. If the access crosses and `LSU_MISALIGN_EN` is undefined, the transition is IDLE -> RESP with `resp_err` = 1 instead.
- BEAT0:
  - Address is `addr & ~7`.
  - Load: `mem_read` = 1, and `mem_rdata` is captured into `lo`.
  - Store: `mem_write` = 1, `mem_wmask = bmask16[7:0]`, `mem_wdata = wdata << (off*8)` (lower 64 bits).
  - Next state is BEAT1 if `cross`, else RESP.
- BEAT1:
  - Address is `(addr & ~7) + 8`.
  - Load: `mem_rdata` is captured into `hi`.
  - Store: `mem_wmask = bmask16[15:8]`, `mem_wdata = (wdata << (off*8)) >> 64`, taken from the 128-bit shift.
  - Next state is RESP.
- RESP:
  - The load result is formed as `({hi,lo} >> (off*8))`, truncated to the access size, then sign-extended, or zero-extended if `req_unsigned`.
  - The result is registered on entry to RESP. `resp_valid` = 1 and holds until `resp_ready`, then the next state is IDLE.
- Outside BEAT0/BEAT1: `mem_read`, `mem_write` and `mem_wmask` are 0. Addresses and `mem_wdata` are 0.
- Request fields are ignored outside IDLE. Only one request is outstanding at a time.
- Address arithmetic wraps modulo 2^64. A crossing access at 0xFFFF_FFFF_FFFF_FFF9 targets 0x0 in BEAT1.

## Timing
- Reset values: state IDLE; `req_ready` = 1; `resp_valid` = 0; `resp_rdata` = 0; `resp_err` = 0; all `mem_*` outputs 0.
- Latency from accept edge T:
  - Single-beat access: beat in cycle T+1, `resp_valid` from T+2.
  - Crossing access: beats in T+1 and T+2, `resp_valid` from T+3.
  - Fault: `resp_valid` from T+1.
- The response is held stable while `resp_valid & !resp_ready`.
- `req_ready` is 0 during RESP, even on the `resp_ready` cycle; the next accept is possible one cycle later.
- Reset asserted in any state: next state IDLE, captured data cleared, and any pending response dropped. If reset lands in BEAT0 of a crossing store, the lower half is written and the upper half is never written.

## Configuration
- `LSU_MISALIGN_EN` defined: crossing accesses are split into two beats and `resp_err` is constant 0.
- `LSU_MISALIGN_EN` undefined:
  - A crossing access issues no memory beat. It responds with `resp_err` = 1 and `resp_rdata` = 0, and memory is unchanged.
  - Misaligned accesses that do not cross, e.g. H at offset 3, are still served normally.

## Structure
- Package `npc_lsu_pkg`: `lsu_size_e` (B/H/W/D) and `lsu_state_e`.
- Sub-module `lsu_align`: purely combinational. It contains the 128-bit write shift and mask generation, and the read merge, shift and extension. It is instantiated once in `npc_lsu`.

## Test plan
- Aligned D store: `addr` 0x8000_0000, `wdata` 0x1122334455667788 -> one beat with `mem_wmask` 0xFF, `mem_waddr` 0x8000_0000. A following D load returns the same value at T+2.
- Byte load: memory word 0x00000000_0000_80FF, `addr` 0x8000_0001 (B, signed) -> `resp_rdata` 0xFFFF_FFFF_FFFF_FF80. With `req_unsigned` = 1 -> 0x80.
- Crossing W store with the macro defined: `addr` 0x8000_0006, `wdata` 0xAABBCCDD -> BEAT0 mask 0xC0 and `wdata` 0xCCDD_0000_0000_0000 at 0x8000_0000; BEAT1 mask 0x03 and `wdata` 0xAABB at 0x8000_0008. A load back returns 0xFFFF_FFFF_AABB_CCDD.
- Same access with the macro undefined -> no `mem_write`; `resp_err` = 1 at T+1; memory unchanged.
- Backpressure: `resp_ready` held at 0 for 5 cycles -> `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0. They release one cycle after `resp_ready`.
- Reset in BEAT1 of a crossing load -> next cycle IDLE, `resp_valid` 0, `req_ready` 1, `mem_read` 0.
